// File: rtl/des_core.sv
// Iterative single-DES engine: one Feistel round per clock, encrypt or decrypt.
// The key schedule rotates C/D on the fly (left for encrypt, right for decrypt).
module des_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        e,
  input  logic [55:0] k,
  input  logic [63:0] in,
  output logic [63:0] out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ip_t [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam int unsigned fp_t [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  localparam int unsigned e_t [48] = '{
    32,1,2,3,4,5,     4,5,6,7,8,9,     8,9,10,11,12,13,  12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

  localparam int unsigned p_t [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

  localparam int unsigned pc1_t [56] = '{
    57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,  21,13,5,28,20,12,4};

  localparam int unsigned pc2_t [48] = '{
    14,17,11,24,1,5,   3,28,15,6,21,10,   23,19,12,4,26,8,   16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  typedef enum logic {st_idle, st_run} state_t;

  state_t      state;
  logic [31:0] l, r, r_n;
  logic [27:0] c, d, c_n, d_n;
  logic [47:0] ki;
  logic [3:0]  rnd;
  logic        enc;

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - ip_t[j])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - fp_t[j])];
    return y;
  endfunction

  // PC-1 is written for the 64-bit key; position p lands at p - (p-1)/8 of k.
  function automatic logic [55:0] perm_pc1(input logic [55:0] x);
    logic [55:0] y;
    int unsigned q;
    y = '0;
    for (int unsigned j = 0; j < 56; j++) begin
      q = pc1_t[j] - (pc1_t[j] - 1) / 8;
      y[6'(55 - j)] = x[6'(56 - q)];
    end
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - pc2_t[j])];
    return y;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - e_t[j])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - p_t[j])];
    return y;
  endfunction

  // Each table is four rows of sixteen nibbles, row-major, row = {b1,b6}.
  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] x);
    logic [255:0] t;
    logic [5:0]   idx;
    case (n)
      3'd0: t = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      3'd1: t = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3'd2: t = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3'd3: t = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      3'd4: t = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      3'd5: t = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      3'd6: t = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: t = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
    idx = {x[5], x[0], x[4:1]};
    return t[{~idx, 2'b11} -: 4];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] x, input logic [47:0] kr);
    logic [47:0] t;
    logic [31:0] s;
    t = expand(x) ^ kr;
    s = '0;
    for (int unsigned i = 0; i < 8; i++)
      s[5'(31 - 4 * i) -: 4] = sbox(3'(i), t[6'(47 - 6 * i) -: 6]);
    return perm_p(s);
  endfunction

  // Rounds 1,2,9,16 shift by one; decrypt skips the shift before round 1.
  always_comb begin
    c_n = c;
    d_n = d;
    if (enc) begin
      if (rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) begin
        c_n = {c[26:0], c[27]};
        d_n = {d[26:0], d[27]};
      end else begin
        c_n = {c[25:0], c[27:26]};
        d_n = {d[25:0], d[27:26]};
      end
    end else if (rnd != 4'd0) begin
      if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) begin
        c_n = {c[0], c[27:1]};
        d_n = {d[0], d[27:1]};
      end else begin
        c_n = {c[1:0], c[27:2]};
        d_n = {d[1:0], d[27:2]};
      end
    end
    ki  = perm_pc2({c_n, d_n});
    r_n = l ^ feistel(r, ki);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rnd   <= '0;
      l     <= '0;
      r     <= '0;
      c     <= '0;
      d     <= '0;
      enc   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        st_idle: begin
          if (start) begin
            {l, r} <= perm_ip(in);
            {c, d} <= perm_pc1(k);
            enc    <= e;
            rnd    <= '0;
            busy   <= 1'b1;
            state  <= st_run;
          end
        end
        st_run: begin
          l   <= r;
          r   <= r_n;
          c   <= c_n;
          d   <= d_n;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd15) begin
            out   <= perm_fp({r_n, r});
            busy  <= 1'b0;
            done  <= 1'b1;
            rnd   <= '0;
            state <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_des_core.sv
// Scoreboard bench for des_core: directed known-answer vectors, handshake
// corner cases, reset abort and a three-stage EDE chain.
`timescale 1ns/1ps
module tb_des_core;

  localparam logic [55:0] key_a = 56'h12695BC9B7B7F8;
  localparam logic [63:0] pt_a  = 64'h0123456789ABCDEF;
  localparam logic [63:0] ct_a  = 64'h85E813540F0AB405;
  localparam logic [63:0] ct_z  = 64'h8CA64DE9C1B123A7;

  logic        clk = 1'b0;
  logic        rst, start, e;
  logic [55:0] k;
  logic [63:0] din, out;
  logic        busy, done;

  logic        ede_start, ede_e;
  logic [55:0] key1, key2;
  logic [63:0] ede_in, s1_out, s2_out, s3_out;
  logic        s1_busy, s1_done, s2_busy, s2_done, s3_busy, s3_done;

  des_core dut (.clk(clk), .rst(rst), .start(start), .e(e), .k(k), .in(din),
                .out(out), .busy(busy), .done(done));

  des_core stage1 (.clk(clk), .rst(rst), .start(ede_start), .e(ede_e), .k(key1),
                   .in(ede_in), .out(s1_out), .busy(s1_busy), .done(s1_done));
  des_core stage2 (.clk(clk), .rst(rst), .start(s1_done), .e(~ede_e), .k(key2),
                   .in(s1_out), .out(s2_out), .busy(s2_busy), .done(s2_done));
  des_core stage3 (.clk(clk), .rst(rst), .start(s2_done), .e(ede_e), .k(key1),
                   .in(s2_out), .out(s3_out), .busy(s3_busy), .done(s3_done));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  logic [63:0] expq[$];
  int unsigned expcyc[$];
  int unsigned done_cnt = 0;
  int unsigned last_done_cyc = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with out=%h expected no done", out);
      end else begin
        check64("sb_out", out, expq.pop_front());
        check_int("sb_latency", cyc, expcyc.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Inputs are scrambled after the start edge; the core must use its copies.
  task automatic issue(input logic ee, input logic [55:0] kk, input logic [63:0] x,
                       input logic [63:0] exp);
    start = 1'b1;
    e     = ee;
    k     = kk;
    din   = x;
    expq.push_back(exp);
    expcyc.push_back(cyc + 17);
    tick();
    start = 1'b0;
    e     = ~ee;
    k     = ~kk;
    din   = ~x;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (expq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in 40 cycles expected done", name);
      expq.delete();
      expcyc.delete();
    end
  endtask

  task automatic run_chain(input logic ee, input logic [63:0] x, input logic [63:0] exp);
    int unsigned n = 0;
    int unsigned t0;
    ede_e     = ee;
    ede_in    = x;
    ede_start = 1'b1;
    t0        = cyc;
    tick();
    ede_start = 1'b0;
    ede_in    = ~x;
    while (!s3_done && n < 80) begin
      tick();
      n++;
    end
    if (!s3_done) begin
      total++;
      bad++;
      $display("FAIL ede_timeout: got no stage3 done expected done");
    end else begin
      check64("ede_out", s3_out, exp);
      check_int("ede_latency", cyc, t0 + 51);
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned first_done;
    int unsigned cnt0;

    rst = 1'b1; start = 1'b0; e = 1'b0; k = '0; din = '0;
    ede_start = 1'b0; ede_e = 1'b0; key1 = '0; key2 = '0; ede_in = '0;
    tick(); tick(); tick();
    check64("reset_out", out, 64'h0);
    check_int("reset_busy", busy, 0);
    check_int("reset_done", done, 0);
    rst = 1'b0;
    tick();

    issue(1'b1, key_a, pt_a, ct_a);
    check_int("busy_after_start", busy, 1);
    drain("kat_enc");
    check_int("busy_after_done", busy, 0);

    issue(1'b0, key_a, ct_a, pt_a);
    drain("kat_dec");

    issue(1'b1, 56'h0, 64'h0, ct_z);
    drain("zero_enc");
    issue(1'b0, 56'h0, ct_z, 64'h0);
    drain("zero_dec");

    // start during rounds is ignored; start in the done cycle is accepted
    issue(1'b1, key_a, pt_a, ct_a);
    repeat (4) tick();
    start = 1'b1; e = 1'b0; din = 64'hDEADBEEFCAFEF00D; k = 56'h0;
    tick();
    start = 1'b0;
    check_int("busy_ignore", busy, 1);
    check64("out_held", out, 64'h0);
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL ignore_timeout: got no done expected done");
    end
    first_done = last_done_cyc;
    issue(1'b1, 56'h0, 64'h0, ct_z);
    drain("done_cycle_start");
    check_int("b2b_spacing", last_done_cyc - first_done, 17);

    // reset in round 8 aborts the block
    issue(1'b1, key_a, pt_a, ct_a);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check_int("abort_busy", busy, 0);
    check_int("abort_done", done, 0);
    check64("abort_out", out, 64'h0);
    expq.delete();
    expcyc.delete();
    rst = 1'b0;
    cnt0 = done_cnt;
    repeat (25) tick();
    check_int("abort_no_done", done_cnt, cnt0);
    issue(1'b0, key_a, ct_a, pt_a);
    drain("after_abort");

    key1 = key_a;
    key2 = key_a;
    run_chain(1'b1, pt_a, ct_a);
    tick();
    run_chain(1'b0, ct_a, pt_a);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

endmodule
